// File: rtl/memory_access.sv
// MEM pipeline stage: drives a handshaked data memory port, resolves branches,
// and loads the MEM/WB buffer. Flags illegal control and ack timeouts via a sticky err.
module memory_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [2:0]  M,
  input  logic [2:0]  WB,
  input  logic [31:0] Alu_result,
  input  logic [31:0] Dato2_M,
  input  logic [4:0]  Direccion,
  input  logic        Zero,
  input  logic [31:0] Add_result,
  input  logic [31:0] jump_address,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        valid_out,
  output logic [2:0]  WB_out,
  output logic [31:0] Read_data,
  output logic [31:0] Alu_result_out,
  output logic [4:0]  Direccion_out,
  output logic [31:0] jump_address_out,
  output logic        err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          start, illegal, done, expire, timeout;

  always_comb begin
    start   = valid_in & (M[2] ^ M[1]);
    illegal = valid_in & M[2] & M[1];
    timeout = (cnt_q == CNT_LAST);
  end

  assign branch_target = Add_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // mem_ack takes priority over the timeout when both land in the same cycle
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    PCSrc   = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        PCSrc = valid_in & M[0] & Zero;
        if (start) state_d = ACCESS;
      end
      ACCESS: begin
        stall = ~mem_ack;
        if (mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      stall = 1'b0;
      PCSrc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q == IDLE)  cnt_q <= '0;
    else if (!timeout)         cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state_q == IDLE && start) begin
      mem_req   <= 1'b1;
      mem_we    <= M[1];
      mem_addr  <= Alu_result;
      mem_wdata <= Dato2_M;
    end else if (done || expire) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err <= 1'b0;
    else if ((state_q == IDLE && illegal) || expire) err <= 1'b1;
  end

  // Upstream holds the instruction while stalled, so buffer fields come straight from the inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out        <= 1'b0;
      WB_out           <= '0;
      Read_data        <= '0;
      Alu_result_out   <= '0;
      Direccion_out    <= '0;
      jump_address_out <= '0;
    end else if (done || (state_q == IDLE && valid_in && !start && !illegal)) begin
      valid_out        <= 1'b1;
      WB_out           <= WB;
      Read_data        <= (done && !mem_we) ? mem_rdata : '0;
      Alu_result_out   <= Alu_result;
      Direccion_out    <= Direccion;
      jump_address_out <= jump_address;
    end else begin
      valid_out        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected MEM/WB entries are queued as
// instructions are driven and compared whenever valid_out is presented.
module tb_memory_access;

  logic        clk, rst_n, valid_in, Zero, mem_ack;
  logic [2:0]  M, WB;
  logic [31:0] Alu_result, Dato2_M, Add_result, jump_address, mem_rdata;
  logic [4:0]  Direccion;
  logic        mem_req, mem_we, stall, PCSrc, valid_out, err;
  logic [31:0] mem_addr, mem_wdata, branch_target, Read_data, Alu_result_out, jump_address_out;
  logic [2:0]  WB_out;
  logic [4:0]  Direccion_out;

  typedef struct {
    logic [2:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dir;
    logic [31:0] jmp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  memory_access #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .M(M), .WB(WB),
    .Alu_result(Alu_result), .Dato2_M(Dato2_M), .Direccion(Direccion), .Zero(Zero),
    .Add_result(Add_result), .jump_address(jump_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .PCSrc(PCSrc),
    .branch_target(branch_target), .valid_out(valid_out), .WB_out(WB_out),
    .Read_data(Read_data), .Alu_result_out(Alu_result_out), .Direccion_out(Direccion_out),
    .jump_address_out(jump_address_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] d2, input logic [4:0] dir, input logic [2:0] wb,
                       input logic [31:0] jmp);
    valid_in     = v;
    M            = m;
    Alu_result   = alu;
    Dato2_M      = d2;
    Direccion    = dir;
    WB           = wb;
    jump_address = jmp;
  endtask

  task automatic push(input logic [31:0] rd);
    sb.push_back('{wb: WB, rd: rd, alu: Alu_result, dir: Direccion, jmp: jump_address});
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && valid_out) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'(valid_out), 0);
      end else begin
        e = sb.pop_front();
        check("sb_read_data", Read_data, e.rd);
        check("sb_alu_result", Alu_result_out, e.alu);
        check("sb_direccion", 32'(Direccion_out), 32'(e.dir));
        check("sb_wb", 32'(WB_out), 32'(e.wb));
        check("sb_jump", jump_address_out, e.jmp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; Zero = 1'b1; Add_result = 32'h40;
    drive(1'b1, 3'b100, 32'h10, 32'h0, 5'd1, 3'b001, 32'h0);
    #12;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_err", 32'(err), 0);
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_stall", 32'(stall), 0);
    M = 3'b001;
    #1;
    check("rst_pcsrc", 32'(PCSrc), 0);
    check("rst_read_data", Read_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    valid_in = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    // load, ack in the second ACCESS cycle
    drive(1'b1, 3'b100, 32'h10, 32'h0, 5'd5, 3'b101, 32'h100);
    Zero = 1'b0;
    #1;
    check("ld_stall_idle", 32'(stall), 1);
    check("ld_req_idle", 32'(mem_req), 0);
    push(32'hDEADBEEF);
    tick();
    check("ld_req_a1", 32'(mem_req), 1);
    check("ld_we_a1", 32'(mem_we), 0);
    check("ld_addr_a1", mem_addr, 32'h10);
    check("ld_stall_a1", 32'(stall), 1);
    check("ld_valid_a1", 32'(valid_out), 0);
    tick();
    check("ld_req_a2", 32'(mem_req), 1);
    mem_rdata = 32'hDEADBEEF; mem_ack = 1'b1;
    #1;
    check("ld_stall_ack", 32'(stall), 0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; valid_in = 1'b0;
    check("ld_req_done", 32'(mem_req), 0);
    check("ld_valid_done", 32'(valid_out), 1);

    // store, immediate ack
    drive(1'b1, 3'b010, 32'h20, 32'h1234, 5'd9, 3'b011, 32'h200);
    #1;
    check("st_stall_idle", 32'(stall), 1);
    push(32'h0);
    tick();
    check("st_req", 32'(mem_req), 1);
    check("st_we", 32'(mem_we), 1);
    check("st_wdata", mem_wdata, 32'h1234);
    check("st_addr", mem_addr, 32'h20);
    mem_rdata = 32'h5555AAAA; mem_ack = 1'b1;
    #1;
    check("st_stall_ack", 32'(stall), 0);
    tick();
    mem_ack = 1'b0; valid_in = 1'b0;
    check("st_req_done", 32'(mem_req), 0);
    check("st_valid_done", 32'(valid_out), 1);

    // stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_req", 32'(mem_req), 0);
    check("idle_ack_valid", 32'(valid_out), 0);
    check("idle_ack_stall", 32'(stall), 0);

    // branch, then back-to-back ALU instructions
    drive(1'b1, 3'b001, 32'h0, 32'h0, 5'd3, 3'b000, 32'h300);
    Zero = 1'b1; Add_result = 32'h40;
    #1;
    check("br_pcsrc_taken", 32'(PCSrc), 1);
    check("br_target", branch_target, 32'h40);
    check("br_stall", 32'(stall), 0);
    Zero = 1'b0;
    #1;
    check("br_pcsrc_not_taken", 32'(PCSrc), 0);
    push(32'h0);
    tick();
    drive(1'b1, 3'b000, 32'hAAAA5555, 32'h0, 5'd31, 3'b111, 32'h400);
    push(32'h0);
    tick();
    drive(1'b1, 3'b000, 32'h12345678, 32'h0, 5'd7, 3'b010, 32'h404);
    push(32'h0);
    tick();
    valid_in = 1'b0;
    tick();
    check("bubble_valid_in0", 32'(valid_out), 0);

    // ack lands in the final ACCESS cycle before timeout
    drive(1'b1, 3'b100, 32'h80, 32'h0, 5'd12, 3'b001, 32'h500);
    push(32'hCAFEF00D);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("late_ack_req", 32'(mem_req), 1);
    mem_rdata = 32'hCAFEF00D; mem_ack = 1'b1;
    #1;
    check("late_ack_stall", 32'(stall), 0);
    tick();
    mem_ack = 1'b0; valid_in = 1'b0;
    check("late_ack_req_done", 32'(mem_req), 0);
    check("late_ack_err", 32'(err), 0);
    check("late_ack_valid", 32'(valid_out), 1);

    // timeout: no ack at all
    drive(1'b1, 3'b100, 32'h90, 32'h0, 5'd13, 3'b001, 32'h600);
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      n++;
      tick();
    end
    check("to_req_cycles", n, 16);
    check("to_err", 32'(err), 1);
    check("to_bubble", 32'(valid_out), 0);
    drive(1'b1, 3'b000, 32'h77, 32'h0, 5'd2, 3'b100, 32'h700);
    push(32'h0);
    tick();
    valid_in = 1'b0;
    check("to_next_valid", 32'(valid_out), 1);

    // reset clears err, then illegal control
    #2; rst_n = 1'b0;
    #1;
    check("rst_err_clear", 32'(err), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1'b1, 3'b110, 32'h30, 32'h99, 5'd6, 3'b001, 32'h800);
    #1;
    check("ill_stall", 32'(stall), 0);
    tick();
    valid_in = 1'b0;
    check("ill_req", 32'(mem_req), 0);
    check("ill_err", 32'(err), 1);
    check("ill_bubble", 32'(valid_out), 0);

    // reset in the third ACCESS cycle
    drive(1'b1, 3'b100, 32'h44, 32'h0, 5'd4, 3'b001, 32'h900);
    tick(); tick(); tick();
    check("mid_req_a3", 32'(mem_req), 1);
    #2; rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 0);
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_err", 32'(err), 0);
    valid_in = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    check("post_req", 32'(mem_req), 0);
    check("post_we", 32'(mem_we), 0);
    check("post_addr", mem_addr, 0);
    check("post_wdata", mem_wdata, 0);
    check("post_valid", 32'(valid_out), 0);
    check("post_read_data", Read_data, 0);
    check("post_alu_out", Alu_result_out, 0);
    check("post_dir_out", 32'(Direccion_out), 0);
    check("post_wb_out", 32'(WB_out), 0);
    check("post_jump_out", jump_address_out, 0);
    check("post_stall", 32'(stall), 0);
    drive(1'b1, 3'b000, 32'h5A5A, 32'h0, 5'd8, 3'b110, 32'hA00);
    push(32'h0);
    tick();
    valid_in = 1'b0;
    check("post_alu_valid", 32'(valid_out), 1);
    tick();

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS-state cycles spent waiting for mem_ack before the access is aborted.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 valid_in  in  1  EX/MEM buffer holds a live instruction.
REQ-006 M  in  3  control bits: [2]=MemRead, [1]=MemWrite, [0]=Branch.
REQ-007 WB  in  3  write-back control, passed through.
REQ-008 Alu_result  in  32  data memory address, or ALU value for write-back.
REQ-009 Dato2_M  in  32  store data.
REQ-010 Direccion  in  5  destination register.
REQ-011 Zero  in  1  ALU zero flag.
REQ-012 Add_result  in  32  branch target.
REQ-013 jump_address  in  32  jump target, passed through.
REQ-014 mem_req / mem_we  out  1/1  memory request and write enable.
REQ-015 mem_addr / mem_wdata  out  32/32  memory address and write data.
REQ-016 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-017 mem_ack  in  1  memory completion strobe, one cycle.
REQ-018 stall  out  1  freezes the upstream stages.
REQ-019 PCSrc  out  1  take the branch.
REQ-020 branch_target  out  32  equals Add_result.
REQ-021 valid_out, WB_out, Read_data, Alu_result_out, Direccion_out, jump_address_out  out  1,3,32,32,5,32  MEM/WB buffer.
REQ-022 err  out  1  sticky error flag.

Function
REQ-023 The FSM SHALL have two states, IDLE and ACCESS.
REQ-024 Going from IDLE to ACCESS SHALL require valid_in=1 and exactly one of MemRead or MemWrite set.
REQ-025 In ACCESS, the block SHALL drive mem_req=1, mem_we=MemWrite, mem_addr=Alu_result and mem_wdata=Dato2_M, all registered at entry and held stable until exit.
REQ-026 stall SHALL be combinational and high in two cases:
 - in IDLE while the ACCESS entry condition is true;
 - in ACCESS while mem_ack=0.
REQ-027 stall SHALL be low in the cycle mem_ack=1.
REQ-028 On mem_ack=1 in ACCESS, the next edge SHALL:
 - return the FSM to IDLE and drop mem_req;
 - load Read_data=mem_rdata (read) or 0 (write);
 - load the MEM/WB buffer with valid_out=1.
REQ-029 mem_ack while in IDLE SHALL be ignored.
REQ-030 A non-memory live instruction SHALL load the MEM/WB buffer one cycle later with Read_data=0 and valid_out=1.
REQ-031 With valid_in=0, the next edge SHALL load valid_out=0, leaving the other buffer fields don't-care.
REQ-032 Upstream inputs SHALL be assumed stable while stall=1.
REQ-033 PCSrc SHALL be combinational: valid_in & Branch & Zero, computed in IDLE only.
REQ-034 PCSrc SHALL be 0 in ACCESS.
REQ-035 MemRead and MemWrite both set SHALL cause:
 - no memory access;
 - err set;
 - a bubble (valid_out=0) on the next edge.
REQ-036 A cycle counter SHALL increment in ACCESS, saturate, and clear on entry.
REQ-037 Reaching TIMEOUT-1 with no ack SHALL:
 - abort the access (mem_req=0 next edge);
 - return the FSM to IDLE and set err;
 - emit a bubble.
REQ-038 mem_ack coinciding with the timeout cycle SHALL win, and the access SHALL complete normally.
REQ-039 err SHALL clear only on reset.

Reset
REQ-040 rst_n=0 SHALL immediately set, asynchronously:
 - state=IDLE, counter=0;
 - mem_req=0, mem_we=0, err=0, valid_out=0;
 - all data outputs 0.
REQ-041 Reset asserted mid-ACCESS SHALL drop mem_req without waiting for the next clock edge, and the in-flight access SHALL be discarded.
REQ-042 Outputs stall and PCSrc SHALL be 0 during reset.

Verification
REQ-043 Load with 2-cycle ack: M=100, Alu_result=0x10, mem_rdata=0xDEADBEEF -> mem_req high for 2 cycles, stall high for 2 cycles; next edge Read_data=0xDEADBEEF, valid_out=1, Direccion_out passed through.
REQ-044 Store with immediate ack: M=010, Dato2_M=0x1234 -> mem_we=1, mem_wdata=0x1234, stall high 1 cycle; buffer Read_data=0.
REQ-045 Branch: M=001, Zero=1, Add_result=0x40 -> PCSrc=1, branch_target=0x40 in the same cycle; with Zero=0 -> PCSrc=0.
REQ-046 Timeout: load with no ack -> mem_req drops after 16 cycles, err=1, valid_out=0; the following ALU instruction passes normally.
REQ-047 Illegal control: M=110 -> no mem_req, err=1, bubble on the next edge.
REQ-048 Reset in the 3rd ACCESS cycle -> mem_req=0 asynchronously; after release, state=IDLE, all outputs 0.
